// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {IDLE, MISS} state_e;

  // Word index within the cache; caller truncates to IDX_W bits.
  function automatic logic [31:0] addr_idx(input logic [31:0] a, input int unsigned idx_w);
    return (a >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag above the index; caller truncates to TAG_W bits.
  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned idx_w);
    return a >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side signals of the instruction cache in one bundle.
interface icache_dm_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_flush;
  logic        i_invalidate;
  logic [31:0] o_inst;
  logic        o_inst_valid;
  logic        o_busy;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic [15:0] o_hit_cnt;
  logic [15:0] o_miss_cnt;

  modport slave (
    input  i_req, i_addr, i_flush, i_invalidate, i_mem_ack, i_mem_rdata,
    output o_inst, o_inst_valid, o_busy, o_mem_req, o_mem_addr, o_hit_cnt, o_miss_cnt
  );

  modport master (
    output i_req, i_addr, i_flush, i_invalidate, i_mem_ack, i_mem_rdata,
    input  o_inst, o_inst_valid, o_busy, o_mem_req, o_mem_addr, o_hit_cnt, o_miss_cnt
  );
endinterface

// File: rtl/icache_array.sv
// Valid bits (reset, global invalidate) plus tag/data storage with one write port
// and combinational read.
module icache_array #(
  parameter int LINES = 64,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inv_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [TAG_W-1:0] wtag_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic             rvalid_o,
  output logic [TAG_W-1:0] rtag_o,
  output logic [31:0]      rdata_o
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Invalidate wins over a same-cycle fill so the fresh entry is also dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       valid_q <= '0;
    else if (inv_i) valid_q <= '0;
    else if (we_i)  valid_q[widx_i] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped one-word-line instruction cache: lookup, req/ack refill FSM,
// flush-aware result drop, deferred invalidate and hit/miss counters.
module icache_dm
  import icache_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic       clk,
  input  logic       rst,
  icache_dm_if.slave bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  logic        inv_pend_q, inv_pend_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        busy_q, busy_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_vld_q, inst_vld_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] lk_idx, wr_idx;
  logic [TAG_W-1:0] lk_tag, wr_tag, arr_tag;
  logic [31:0]      arr_data;
  logic             arr_valid, arr_we, arr_inv, lk_hit;

  assign lk_idx = IDX_W'(addr_idx(bus.i_addr, IDX_W));
  assign lk_tag = TAG_W'(addr_tag(bus.i_addr, IDX_W));
  assign wr_idx = IDX_W'(addr_idx(mem_addr_q, IDX_W));
  assign wr_tag = TAG_W'(addr_tag(mem_addr_q, IDX_W));

  icache_array #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clk      (clk),
    .rst      (rst),
    .inv_i    (arr_inv),
    .we_i     (arr_we),
    .widx_i   (wr_idx),
    .wtag_i   (wr_tag),
    .wdata_i  (bus.i_mem_rdata),
    .ridx_i   (lk_idx),
    .rvalid_o (arr_valid),
    .rtag_o   (arr_tag),
    .rdata_o  (arr_data)
  );

  // A same-cycle invalidate forces the lookup to miss.
  assign lk_hit = arr_valid && (arr_tag == lk_tag) && !bus.i_invalidate;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      drop_q     <= 1'b0;
      inv_pend_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      inst_q     <= '0;
      inst_vld_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      inv_pend_q <= inv_pend_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      inst_q     <= inst_d;
      inst_vld_q <= inst_vld_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    inv_pend_d = inv_pend_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    busy_d     = busy_q;
    inst_d     = inst_q;
    inst_vld_d = inst_vld_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    arr_we     = 1'b0;
    arr_inv    = 1'b0;
    unique case (state_q)
      IDLE: begin
        arr_inv    = bus.i_invalidate;
        inst_vld_d = 1'b0;
        if (bus.i_req) begin
          if (lk_hit) begin
            inst_d     = arr_data;
            inst_vld_d = 1'b1;
            hit_cnt_d  = hit_cnt_q + 16'd1;
          end else begin
            mem_req_d  = 1'b1;
            busy_d     = 1'b1;
            mem_addr_d = {bus.i_addr[31:2], 2'b00};
            miss_cnt_d = miss_cnt_q + 16'd1;
            drop_d     = 1'b0;
            inv_pend_d = 1'b0;
            state_d    = MISS;
          end
        end
      end
      MISS: begin
        if (bus.i_flush)      drop_d     = 1'b1;
        if (bus.i_invalidate) inv_pend_d = 1'b1;
        if (bus.i_mem_ack) begin
          arr_we     = 1'b1;
          arr_inv    = inv_pend_q | bus.i_invalidate;
          mem_req_d  = 1'b0;
          busy_d     = 1'b0;
          inst_d     = bus.i_mem_rdata;
          inst_vld_d = !(drop_q | bus.i_flush);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_inst       = inst_q;
  assign bus.o_inst_valid = inst_vld_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_mem_req    = mem_req_q;
  assign bus.o_mem_addr   = mem_addr_q;
  assign bus.o_hit_cnt    = hit_cnt_q;
  assign bus.o_miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, hit, conflict, flush/invalidate during
// refill, stray ack, back-to-back hits and async reset mid-refill.
module tb_icache_dm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  icache_dm_if bus();

  icache_dm #(.LINES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack(input logic [31:0] d, input logic f);
    bus.i_req       = 1'b0;
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = d;
    bus.i_flush     = f;
    cyc();
    bus.i_mem_ack   = 1'b0;
    bus.i_flush     = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] a, input logic inv);
    bus.i_req        = 1'b1;
    bus.i_addr       = a;
    bus.i_invalidate = inv;
    cyc();
    bus.i_req        = 1'b0;
    bus.i_invalidate = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    repeat (2) cyc();
    checks++; if (bus.o_inst !== 32'h0)       begin errs++; $display("FAIL rst_inst: got %h want 0", bus.o_inst); end
    checks++; if (bus.o_inst_valid !== 1'b0)  begin errs++; $display("FAIL rst_valid: got %b want 0", bus.o_inst_valid); end
    checks++; if (bus.o_busy !== 1'b0)        begin errs++; $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_mem_req !== 1'b0)     begin errs++; $display("FAIL rst_memreq: got %b want 0", bus.o_mem_req); end
    checks++; if (bus.o_mem_addr !== 32'h0)   begin errs++; $display("FAIL rst_memaddr: got %h want 0", bus.o_mem_addr); end
    checks++; if (bus.o_hit_cnt !== 16'h0)    begin errs++; $display("FAIL rst_hit: got %0d want 0", bus.o_hit_cnt); end
    checks++; if (bus.o_miss_cnt !== 16'h0)   begin errs++; $display("FAIL rst_miss: got %0d want 0", bus.o_miss_cnt); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_cold_miss();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    cyc();
    checks++; if (bus.o_mem_req !== 1'b1)      begin errs++; $display("FAIL cold_memreq: got %b want 1", bus.o_mem_req); end
    checks++; if (bus.o_mem_addr !== 32'h100)  begin errs++; $display("FAIL cold_memaddr: got %h want 100", bus.o_mem_addr); end
    checks++; if (bus.o_busy !== 1'b1)         begin errs++; $display("FAIL cold_busy: got %b want 1", bus.o_busy); end
    checks++; if (bus.o_inst_valid !== 1'b0)   begin errs++; $display("FAIL cold_valid0: got %b want 0", bus.o_inst_valid); end
    checks++; if (bus.o_miss_cnt !== 16'd1)    begin errs++; $display("FAIL cold_misscnt: got %0d want 1", bus.o_miss_cnt); end
    bus.i_addr = 32'h999;
    cyc();
    checks++; if (bus.o_mem_addr !== 32'h100)  begin errs++; $display("FAIL cold_addr_stable: got %h want 100", bus.o_mem_addr); end
    checks++; if (bus.o_miss_cnt !== 16'd1)    begin errs++; $display("FAIL cold_req_ignored: got %0d want 1", bus.o_miss_cnt); end
    bus.i_req = 1'b0;
    cyc();
    do_ack(32'h00500093, 1'b0);
    checks++; if (bus.o_inst !== 32'h00500093) begin errs++; $display("FAIL cold_inst: got %h want 00500093", bus.o_inst); end
    checks++; if (bus.o_inst_valid !== 1'b1)   begin errs++; $display("FAIL cold_valid: got %b want 1", bus.o_inst_valid); end
    checks++; if (bus.o_mem_req !== 1'b0)      begin errs++; $display("FAIL cold_memreq_drop: got %b want 0", bus.o_mem_req); end
    checks++; if (bus.o_busy !== 1'b0)         begin errs++; $display("FAIL cold_busy_drop: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_hit();
    lookup(32'h100, 1'b0);
    checks++; if (bus.o_inst !== 32'h00500093) begin errs++; $display("FAIL hit_inst: got %h want 00500093", bus.o_inst); end
    checks++; if (bus.o_inst_valid !== 1'b1)   begin errs++; $display("FAIL hit_valid: got %b want 1", bus.o_inst_valid); end
    checks++; if (bus.o_mem_req !== 1'b0)      begin errs++; $display("FAIL hit_memreq: got %b want 0", bus.o_mem_req); end
    checks++; if (bus.o_hit_cnt !== 16'd1)     begin errs++; $display("FAIL hit_cnt: got %0d want 1", bus.o_hit_cnt); end
    cyc();
    checks++; if (bus.o_inst_valid !== 1'b0)   begin errs++; $display("FAIL hit_idle_valid: got %b want 0", bus.o_inst_valid); end
    checks++; if (bus.o_inst !== 32'h00500093) begin errs++; $display("FAIL hit_idle_hold: got %h want 00500093", bus.o_inst); end
  endtask

  task automatic test_conflict();
    lookup(32'h200, 1'b0);
    checks++; if (bus.o_mem_addr !== 32'h200)  begin errs++; $display("FAIL conf_addr200: got %h want 200", bus.o_mem_addr); end
    checks++; if (bus.o_mem_req !== 1'b1)      begin errs++; $display("FAIL conf_req200: got %b want 1", bus.o_mem_req); end
    do_ack(32'h11111111, 1'b0);
    checks++; if (bus.o_inst !== 32'h11111111) begin errs++; $display("FAIL conf_inst200: got %h want 11111111", bus.o_inst); end
    lookup(32'h100, 1'b0);
    checks++; if (bus.o_mem_addr !== 32'h100)  begin errs++; $display("FAIL conf_addr100: got %h want 100", bus.o_mem_addr); end
    do_ack(32'h00500093, 1'b0);
    checks++; if (bus.o_miss_cnt !== 16'd3)    begin errs++; $display("FAIL conf_misscnt: got %0d want 3", bus.o_miss_cnt); end
    checks++; if (bus.o_inst_valid !== 1'b1)   begin errs++; $display("FAIL conf_valid: got %b want 1", bus.o_inst_valid); end
  endtask

  task automatic test_flush();
    lookup(32'h40, 1'b0);
    checks++; if (bus.o_mem_req !== 1'b1)      begin errs++; $display("FAIL fl_req: got %b want 1", bus.o_mem_req); end
    bus.i_flush = 1'b1;
    cyc();
    bus.i_flush = 1'b0;
    cyc();
    do_ack(32'hDEADBEEF, 1'b0);
    checks++; if (bus.o_inst_valid !== 1'b0)   begin errs++; $display("FAIL fl_dropped: got %b want 0", bus.o_inst_valid); end
    checks++; if (bus.o_busy !== 1'b0)         begin errs++; $display("FAIL fl_busy: got %b want 0", bus.o_busy); end
    lookup(32'h40, 1'b0);
    checks++; if (bus.o_inst !== 32'hDEADBEEF) begin errs++; $display("FAIL fl_hit_inst: got %h want deadbeef", bus.o_inst); end
    checks++; if (bus.o_inst_valid !== 1'b1)   begin errs++; $display("FAIL fl_hit_valid: got %b want 1", bus.o_inst_valid); end
    checks++; if (bus.o_hit_cnt !== 16'd2)     begin errs++; $display("FAIL fl_hit_cnt: got %0d want 2", bus.o_hit_cnt); end
    // flush coincident with ack also drops the result
    lookup(32'h44, 1'b0);
    do_ack(32'hAAAA5555, 1'b1);
    checks++; if (bus.o_inst_valid !== 1'b0)   begin errs++; $display("FAIL fl_ackcyc: got %b want 0", bus.o_inst_valid); end
    lookup(32'h44, 1'b0);
    checks++; if (bus.o_inst !== 32'hAAAA5555) begin errs++; $display("FAIL fl_ackcyc_hit: got %h want aaaa5555", bus.o_inst); end
    checks++; if (bus.o_hit_cnt !== 16'd3)     begin errs++; $display("FAIL fl_hit_cnt2: got %0d want 3", bus.o_hit_cnt); end
  endtask

  task automatic test_stray_ack();
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h12345678;
    cyc();
    bus.i_mem_ack   = 1'b0;
    checks++; if (bus.o_inst_valid !== 1'b0)   begin errs++; $display("FAIL stray_valid: got %b want 0", bus.o_inst_valid); end
    checks++; if (bus.o_inst !== 32'hAAAA5555) begin errs++; $display("FAIL stray_inst: got %h want aaaa5555", bus.o_inst); end
    checks++; if (bus.o_busy !== 1'b0)         begin errs++; $display("FAIL stray_busy: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_invalidate();
    lookup(32'h80, 1'b0);
    bus.i_invalidate = 1'b1;
    cyc();
    bus.i_invalidate = 1'b0;
    cyc();
    do_ack(32'hCAFEF00D, 1'b0);
    checks++; if (bus.o_inst_valid !== 1'b1)   begin errs++; $display("FAIL inv_valid: got %b want 1", bus.o_inst_valid); end
    checks++; if (bus.o_inst !== 32'hCAFEF00D) begin errs++; $display("FAIL inv_inst: got %h want cafef00d", bus.o_inst); end
    lookup(32'h80, 1'b0);
    checks++; if (bus.o_mem_req !== 1'b1)      begin errs++; $display("FAIL inv_remiss: got %b want 1", bus.o_mem_req); end
    checks++; if (bus.o_miss_cnt !== 16'd7)    begin errs++; $display("FAIL inv_misscnt: got %0d want 7", bus.o_miss_cnt); end
    do_ack(32'hCAFEF00D, 1'b0);
    lookup(32'h80, 1'b0);
    checks++; if (bus.o_hit_cnt !== 16'd4)     begin errs++; $display("FAIL inv_hit: got %0d want 4", bus.o_hit_cnt); end
    // invalidate alongside an IDLE lookup turns a would-be hit into a miss
    lookup(32'h80, 1'b1);
    checks++; if (bus.o_mem_req !== 1'b1)      begin errs++; $display("FAIL inv_idle_miss: got %b want 1", bus.o_mem_req); end
    checks++; if (bus.o_miss_cnt !== 16'd8)    begin errs++; $display("FAIL inv_idle_cnt: got %0d want 8", bus.o_miss_cnt); end
    do_ack(32'hCAFEF00D, 1'b0);
  endtask

  task automatic test_back_to_back();
    lookup(32'h100, 1'b0);
    do_ack(32'h00500093, 1'b0);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    cyc();
    checks++; if (bus.o_inst !== 32'h00500093) begin errs++; $display("FAIL b2b_inst0: got %h want 00500093", bus.o_inst); end
    bus.i_addr = 32'h80;
    cyc();
    bus.i_req = 1'b0;
    checks++; if (bus.o_inst !== 32'hCAFEF00D) begin errs++; $display("FAIL b2b_inst1: got %h want cafef00d", bus.o_inst); end
    checks++; if (bus.o_inst_valid !== 1'b1)   begin errs++; $display("FAIL b2b_valid: got %b want 1", bus.o_inst_valid); end
    checks++; if (bus.o_hit_cnt !== 16'd6)     begin errs++; $display("FAIL b2b_hitcnt: got %0d want 6", bus.o_hit_cnt); end
  endtask

  task automatic test_reset_mid_miss();
    lookup(32'h104, 1'b0);
    checks++; if (bus.o_busy !== 1'b1)         begin errs++; $display("FAIL rm_busy_pre: got %b want 1", bus.o_busy); end
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (bus.o_mem_req !== 1'b0)      begin errs++; $display("FAIL rm_memreq: got %b want 0", bus.o_mem_req); end
    checks++; if (bus.o_busy !== 1'b0)         begin errs++; $display("FAIL rm_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_hit_cnt !== 16'd0)     begin errs++; $display("FAIL rm_hit: got %0d want 0", bus.o_hit_cnt); end
    checks++; if (bus.o_miss_cnt !== 16'd0)    begin errs++; $display("FAIL rm_miss: got %0d want 0", bus.o_miss_cnt); end
    cyc();
    rst = 1'b1;
    cyc();
    lookup(32'h100, 1'b0);
    checks++; if (bus.o_mem_req !== 1'b1)      begin errs++; $display("FAIL rm_100_miss: got %b want 1", bus.o_mem_req); end
    checks++; if (bus.o_miss_cnt !== 16'd1)    begin errs++; $display("FAIL rm_misscnt: got %0d want 1", bus.o_miss_cnt); end
    do_ack(32'h00500093, 1'b0);
    checks++; if (bus.o_inst_valid !== 1'b1)   begin errs++; $display("FAIL rm_refill: got %b want 1", bus.o_inst_valid); end
  endtask

  initial begin
    bus.i_req        = 1'b0;
    bus.i_addr       = 32'h0;
    bus.i_flush      = 1'b0;
    bus.i_invalidate = 1'b0;
    bus.i_mem_ack    = 1'b0;
    bus.i_mem_rdata  = 32'h0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_stray_ack();
    test_invalidate();
    test_back_to_back();
    test_reset_mid_miss();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
